noc_packetizer: RTL and testbench

Local network interface on the injection side of a mesh router. It takes a send request (destination coordinates and body length) plus a stream of payload words, and emits a well-formed wormhole packet into the router's local input port. The head flit carries dst_x/dst_y, which the router's XY route computation consumes downstream. Sits between a core/DMA and router local port 0.

---
 rtl/noc_packetizer.sv | 137 +++++++++++++
 tb/tb_noc_packetizer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packetizer.sv
// Injection-side network interface: turns a send request plus a payload stream
// into a HEAD/BODY/TAIL (or HEADTAIL) wormhole packet for the router local port.
module noc_packetizer #(
  parameter  int X_WIDTH    = 2,
  parameter  int Y_WIDTH    = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_LEN    = 4,
  localparam int LEN_W      = $clog2(MAX_LEN+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [X_WIDTH-1:0]    id_x,
  input  logic [Y_WIDTH-1:0]    id_y,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [X_WIDTH-1:0]    req_dst_x,
  input  logic [Y_WIDTH-1:0]    req_dst_y,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [1:0]            flit_type,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic                  busy,
  output logic                  err_len,
  output logic [15:0]           pkt_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAD = 2'd1;
  localparam logic [1:0] BODY = 2'd2;

  localparam logic [1:0] FT_HEAD     = 2'b00;
  localparam logic [1:0] FT_BODY     = 2'b01;
  localparam logic [1:0] FT_TAIL     = 2'b10;
  localparam logic [1:0] FT_HEADTAIL = 2'b11;

  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);

  // Packed MSB-first, so dst_y lands in the flit LSBs.
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [X_WIDTH-1:0] src_x;
    logic [Y_WIDTH-1:0] src_y;
    logic [X_WIDTH-1:0] dst_x;
    logic [Y_WIDTH-1:0] dst_y;
  } hdr_t;

  localparam int HDR_W = $bits(hdr_t);

  logic [1:0]            state;
  logic [X_WIDTH-1:0]    dst_x;
  logic [Y_WIDTH-1:0]    dst_y;
  logic [LEN_W-1:0]      len;
  logic [LEN_W-1:0]      remaining;
  hdr_t                  hdr;
  logic [DATA_WIDTH-1:0] hdr_data;

  always_comb begin
    hdr.len   = len;
    hdr.src_x = id_x;
    hdr.src_y = id_y;
    hdr.dst_x = dst_x;
    hdr.dst_y = dst_y;
    hdr_data  = '0;
    hdr_data[HDR_W-1:0] = hdr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dst_x     <= '0;
      dst_y     <= '0;
      len       <= '0;
      remaining <= '0;
      err_len   <= 1'b0;
      pkt_count <= '0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          dst_x   <= req_dst_x;
          dst_y   <= req_dst_y;
          len     <= (req_len > MAXL) ? MAXL : req_len;
          err_len <= (req_len > MAXL);
          state   <= HEAD;
        end
        HEAD: if (flit_ready) begin
          if (len == '0) begin
            state     <= IDLE;
            pkt_count <= pkt_count + 16'd1;
          end else begin
            state     <= BODY;
            remaining <= len;
          end
        end
        BODY: if (data_valid && flit_ready) begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state     <= IDLE;
            pkt_count <= pkt_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Body flits are a straight pass-through of the payload handshake.
  always_comb begin
    req_ready  = 1'b0;
    data_ready = 1'b0;
    flit_valid = 1'b0;
    flit_type  = FT_HEAD;
    flit_data  = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      HEAD: begin
        flit_valid = 1'b1;
        flit_type  = (len == '0) ? FT_HEADTAIL : FT_HEAD;
        flit_data  = hdr_data;
      end
      BODY: begin
        flit_valid = data_valid;
        data_ready = flit_ready;
        flit_type  = (remaining == LEN_W'(1)) ? FT_TAIL : FT_BODY;
        flit_data  = data_in;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer: expected flits queued at request time and
// checked against every flit handshake the router side sees.
module tb_noc_packetizer;
  localparam int XW = 2, YW = 2, DW = 32, ML = 4, LW = 3;

  logic          clk, rst_n;
  logic [XW-1:0] id_x, req_dst_x;
  logic [YW-1:0] id_y, req_dst_y;
  logic          req_valid, req_ready;
  logic [LW-1:0] req_len;
  logic          data_valid, data_ready;
  logic [DW-1:0] data_in;
  logic          flit_valid, flit_ready;
  logic [1:0]    flit_type;
  logic [DW-1:0] flit_data;
  logic          busy, err_len;
  logic [15:0]   pkt_count;

  typedef struct packed { logic [1:0] t; logic [DW-1:0] d; } flit_t;

  flit_t         exp_q[$];
  logic [DW-1:0] src_q[$];
  int            hs_cyc[$];
  logic [1:0]    hs_typ[$];
  int tests = 0, fails = 0, cyc = 0;
  int req_left = 0, busy_cnt, dr_cnt, dhs_cnt, err_cnt;
  bit src_en = 0, req_hs, data_hs;

  noc_packetizer #(.X_WIDTH(XW), .Y_WIDTH(YW), .DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .id_x(id_x), .id_y(id_y),
    .req_valid(req_valid), .req_ready(req_ready), .req_dst_x(req_dst_x),
    .req_dst_y(req_dst_y), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_type(flit_type),
    .flit_data(flit_data), .busy(busy), .err_len(err_len), .pkt_count(pkt_count)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  // Header model for this node at (1,2): {len, src_x, src_y, dst_x, dst_y}.
  function automatic logic [DW-1:0] hdr(input logic [1:0] dx, input logic [1:0] dy,
                                         input logic [2:0] l);
    hdr = '0;
    hdr[10:0] = {l, 2'd1, 2'd2, dx, dy};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    req_valid  = (req_left > 0);
    data_valid = src_en && (src_q.size() > 0);
    data_in    = (src_q.size() > 0) ? src_q[0] : '0;
  endtask

  task automatic cycle();
    flit_t e;
    @(negedge clk);
    cyc++;
    busy_cnt += int'(busy);
    dr_cnt   += int'(data_ready);
    err_cnt  += int'(err_len);
    req_hs  = req_valid && req_ready;
    data_hs = data_valid && data_ready;
    if (flit_valid && flit_ready) begin
      hs_cyc.push_back(cyc);
      hs_typ.push_back(flit_type);
      if (exp_q.size() == 0) chk("unexpected_flit", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("flit_type", 64'(flit_type), 64'(e.t));
        chk("flit_data", 64'(flit_data), 64'(e.d));
      end
    end
    @(posedge clk); #1;
    if (req_hs) req_left--;
    if (data_hs) begin src_q.delete(0); dhs_cnt++; end
    drive();
  endtask

  task automatic clr();
    busy_cnt = 0; dr_cnt = 0; dhs_cnt = 0; err_cnt = 0;
    hs_cyc.delete(); hs_typ.delete();
  endtask

  task automatic req(input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] l,
                     input int n);
    req_dst_x = dx; req_dst_y = dy; req_len = l; req_left = n;
    drive();
  endtask

  task automatic push(input logic [1:0] t, input logic [DW-1:0] d);
    exp_q.push_back('{t: t, d: d});
  endtask

  task automatic settle(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || busy || req_left > 0) && k < 50) begin cycle(); k++; end
    chk({tag, "_timeout"}, 64'(k < 50), 64'd1);
  endtask

  initial begin
    rst_n = 0; id_x = 2'd1; id_y = 2'd2; flit_ready = 1;
    req_dst_x = 0; req_dst_y = 0; req_len = 0; req_valid = 0;
    data_valid = 0; data_in = 0;
    clr();
    cycle(); cycle();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_flit_type", 64'(flit_type), 64'd0);
    chk("rst_flit_data", 64'(flit_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_len", 64'(err_len), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    rst_n = 1;

    // Head-only packet.
    clr();
    push(2'b11, hdr(2'd3, 2'd0, 3'd0));
    req(2'd3, 2'd0, 3'd0, 1);
    settle("t1");
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd1);
    chk("t1_flits", 64'(hs_cyc.size()), 64'd1);
    chk("t1_pkt_count", 64'(pkt_count), 64'd1);

    // Three-word body, everything streaming.
    clr();
    src_q = '{32'hA, 32'hB, 32'hC}; src_en = 1;
    push(2'b00, hdr(2'd2, 2'd1, 3'd3));
    push(2'b01, 32'hA); push(2'b01, 32'hB); push(2'b10, 32'hC);
    req(2'd2, 2'd1, 3'd3, 1);
    settle("t2");
    chk("t2_flits", 64'(hs_cyc.size()), 64'd4);
    chk("t2_consecutive", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
    chk("t2_data_ready_cycles", 64'(dr_cnt), 64'd3);
    chk("t2_pkt_count", 64'(pkt_count), 64'd2);

    // Head stalled four cycles, then gappy payload.
    clr();
    flit_ready = 0; src_en = 0;
    src_q = '{32'hD1, 32'hD2};
    push(2'b00, hdr(2'd0, 2'd1, 3'd2));
    push(2'b01, 32'hD1); push(2'b10, 32'hD2);
    req(2'd0, 2'd1, 3'd2, 1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall_valid", 64'(flit_valid), 64'd1);
      chk("t3_stall_type", 64'(flit_type), 64'd0);
      chk("t3_stall_data", 64'(flit_data), 64'(hdr(2'd0, 2'd1, 3'd2)));
      chk("t3_stall_data_ready", 64'(data_ready), 64'd0);
      cycle();
    end
    flit_ready = 1; cycle();
    src_en = 1; drive(); cycle();
    src_en = 0; drive(); cycle();
    src_en = 1; drive(); cycle();
    settle("t3");
    chk("t3_body_handshakes", 64'(dhs_cnt), 64'd2);
    chk("t3_last_type", 64'(hs_typ[hs_typ.size()-1]), 64'd2);
    chk("t3_pkt_count", 64'(pkt_count), 64'd3);

    // Oversized length gets clamped to MAX_LEN.
    clr();
    src_q = '{32'h40, 32'h41, 32'h42, 32'h43};
    push(2'b00, hdr(2'd0, 2'd3, 3'd4));
    push(2'b01, 32'h40); push(2'b01, 32'h41); push(2'b01, 32'h42); push(2'b10, 32'h43);
    req(2'd0, 2'd3, 3'd7, 1);
    settle("t4");
    chk("t4_err_pulses", 64'(err_cnt), 64'd1);
    chk("t4_body_handshakes", 64'(dhs_cnt), 64'd4);
    chk("t4_pkt_count", 64'(pkt_count), 64'd4);

    // Reset in the middle of a len=4 packet abandons it.
    clr();
    src_q = '{32'h50, 32'h51, 32'h52, 32'h53};
    push(2'b00, hdr(2'd1, 2'd1, 3'd4));
    push(2'b01, 32'h50); push(2'b01, 32'h51); push(2'b01, 32'h52); push(2'b10, 32'h53);
    req(2'd1, 2'd1, 3'd4, 1);
    begin
      int k = 0;
      while (dhs_cnt < 2 && k < 20) begin cycle(); k++; end
      chk("t5_timeout", 64'(k < 20), 64'd1);
    end
    rst_n = 0;
    exp_q.delete(); src_q.delete(); req_left = 0; drive();
    cycle();
    chk("t5_flit_valid", 64'(flit_valid), 64'd0);
    chk("t5_req_ready", 64'(req_ready), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    // Reset clears the counter; the abandoned packet must not have bumped it.
    chk("t5_pkt_count", 64'(pkt_count), 64'd0);
    rst_n = 1;
    clr();
    src_q = '{32'h60};
    push(2'b00, hdr(2'd2, 2'd2, 3'd1)); push(2'b10, 32'h60);
    req(2'd2, 2'd2, 3'd1, 1);
    settle("t5b");
    chk("t5b_pkt_count", 64'(pkt_count), 64'd1);

    // Back-to-back len=1 packets with req_valid held.
    clr();
    src_q = '{32'h70, 32'h71};
    push(2'b00, hdr(2'd3, 2'd3, 3'd1)); push(2'b10, 32'h70);
    push(2'b00, hdr(2'd3, 2'd3, 3'd1)); push(2'b10, 32'h71);
    req(2'd3, 2'd3, 3'd1, 2);
    settle("t6");
    chk("t6_flits", 64'(hs_cyc.size()), 64'd4);
    chk("t6_gap", 64'(hs_cyc[2] - hs_cyc[1]), 64'd2);
    chk("t6_pkt_count", 64'(pkt_count), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
